// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-port bundle between the core's memory clients and mem_port_arbiter.
// Latency: none (wires only).
// Backpressure: per-client valid/ready on requests; responses are never back-pressured.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_valid;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_rsp_valid;
    logic [DATA_WIDTH-1:0] fetch_rsp_data;

    logic                  load_valid;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  load_ready;
    logic                  load_rsp_valid;
    logic [DATA_WIDTH-1:0] load_rsp_data;

    logic                  store_valid;
    logic [ADDR_WIDTH-1:0] store_addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  store_ready;
    logic                  store_rsp_valid;

    logic                  rsp_exc_valid;
    logic [3:0]            rsp_exc_code;
    logic                  flush;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side: takes requests and read data, drives grants, responses and the memory strobe.
    modport slave (
        input  fetch_valid, fetch_addr, load_valid, load_addr,
        input  store_valid, store_addr, store_data, flush, mem_rdata,
        output fetch_ready, fetch_rsp_valid, fetch_rsp_data,
        output load_ready, load_rsp_valid, load_rsp_data,
        output store_ready, store_rsp_valid, rsp_exc_valid, rsp_exc_code,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_valid, fetch_addr, load_valid, load_addr,
        output store_valid, store_addr, store_data, flush, mem_rdata,
        input  fetch_ready, fetch_rsp_valid, fetch_rsp_data,
        input  load_ready, load_rsp_valid, load_rsp_data,
        input  store_ready, store_rsp_valid, rsp_exc_valid, rsp_exc_code,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between fetch, load and store, with tag-routed responses.
// Latency: grant and memory strobe are combinational; each response appears MEM_LATENCY cycles after acceptance.
// Backpressure: at most one ready per cycle; responses are never stalled.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] CL_FETCH = 2'd0;
    localparam logic [1:0] CL_LOAD  = 2'd1;
    localparam logic [1:0] CL_STORE = 2'd2;

    typedef struct packed {
        logic       vld;
        logic [1:0] client;
        logic       err;
        logic [3:0] code;
    } tag_t;

    logic [1:0]            last_grant;
    tag_t                  tag_q    [MEM_LATENCY];
    tag_t                  tag_kill [MEM_LATENCY];
    tag_t                  tag_new;
    tag_t                  tag_out;
    logic [2:0]            req;
    logic [2:0]            gnt;
    logic                  gnt_any;
    logic                  gnt_mis;
    logic [1:0]            gnt_client;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    // Reset gates the requests so every ready and the memory strobe read 0 while RESET is low.
    assign req = {bus.store_valid, bus.load_valid, bus.fetch_valid & ~bus.flush} & {3{RESET}};

    always_comb begin
        gnt = 3'b000;
        case (last_grant)
            CL_FETCH: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            CL_LOAD: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        gnt_client = CL_FETCH;
        gnt_addr   = bus.fetch_addr;
        if (gnt[1]) begin
            gnt_client = CL_LOAD;
            gnt_addr   = bus.load_addr;
        end else if (gnt[2]) begin
            gnt_client = CL_STORE;
            gnt_addr   = bus.store_addr;
        end
    end

    assign gnt_any = |gnt;
    assign gnt_mis = gnt_any & (|gnt_addr[1:0]);

    assign bus.fetch_ready = gnt[0];
    assign bus.load_ready  = gnt[1];
    assign bus.store_ready = gnt[2];

    // A misaligned request is accepted but never reaches memory; only its error tag travels on.
    assign bus.mem_en    = gnt_any & ~gnt_mis;
    assign bus.mem_we    = bus.mem_en & gnt[2];
    assign bus.mem_addr  = bus.mem_en ? gnt_addr : '0;
    assign bus.mem_wdata = (bus.mem_en & gnt[2]) ? bus.store_data : '0;

    always_comb begin
        tag_new        = '0;
        tag_new.vld    = gnt_any;
        tag_new.client = gnt_client;
        tag_new.err    = gnt_mis;
        if (gnt_mis) begin
            case (gnt_client)
                CL_LOAD:  tag_new.code = 4'd4;
                CL_STORE: tag_new.code = 4'd6;
                default:  tag_new.code = 4'd0;
            endcase
        end
    end

    // Flush kills fetch tags before they shift or exit, so the exiting one is suppressed too.
    always_comb begin
        for (int i = 0; i < MEM_LATENCY; i++) begin
            tag_kill[i] = tag_q[i];
            if (bus.flush && (tag_q[i].client == CL_FETCH)) tag_kill[i].vld = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant <= CL_STORE;
            for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            if (gnt_any) last_grant <= gnt_client;
            tag_q[0] <= tag_new;
            for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_kill[i-1];
        end
    end

    assign tag_out = tag_kill[MEM_LATENCY-1];

    assign bus.fetch_rsp_valid = tag_out.vld & (tag_out.client == CL_FETCH);
    assign bus.load_rsp_valid  = tag_out.vld & (tag_out.client == CL_LOAD);
    assign bus.store_rsp_valid = tag_out.vld & (tag_out.client == CL_STORE);
    assign bus.rsp_exc_valid   = tag_out.vld & tag_out.err;
    assign bus.rsp_exc_code    = bus.rsp_exc_valid ? tag_out.code : 4'd0;
    assign bus.fetch_rsp_data  = (bus.fetch_rsp_valid & ~tag_out.err) ? bus.mem_rdata : '0;
    assign bus.load_rsp_data   = (bus.load_rsp_valid & ~tag_out.err) ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory32 port between the processor core's three memory clients: instruction fetch, data load and data store.
- Grants one request per cycle using round-robin arbitration and drives the memory port.
- Tracks in-flight accesses in a tag pipeline and routes each read data or write acknowledge back to the client that issued it.
- Sits between proc_core's fetch/memRead/memWrite interfaces and the memory model.

Parameters:
ADDR_WIDTH, 32, address width of all requests and the memory port
DATA_WIDTH, 32, read/write data width
MEM_LATENCY, 1, memory read latency in cycles, from accepted request to mem_rdata valid; legal range 1..4

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
fetch_valid  input  1  fetch request pending
fetch_addr  input  ADDR_WIDTH  fetch address
fetch_ready  output  1  fetch request accepted this cycle
fetch_rsp_valid  output  1  fetch response valid
fetch_rsp_data  output  DATA_WIDTH  instruction word
load_valid  input  1  load request pending
load_addr  input  ADDR_WIDTH  load address
load_ready  output  1  load accepted this cycle
load_rsp_valid  output  1  load response valid
load_rsp_data  output  DATA_WIDTH  load data
store_valid  input  1  store request pending
store_addr  input  ADDR_WIDTH  store address
store_data  input  DATA_WIDTH  store data
store_ready  output  1  store accepted this cycle
store_rsp_valid  output  1  store acknowledge
rsp_exc_valid  output  1  exception flag attached to the response valid this cycle
rsp_exc_code  output  4  exception cause attached to that response
flush  input  1  discard all in-flight and same-cycle fetch responses
mem_en  output  1  memory access strobe
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_en with mem_we=0

Behaviour:
- Reset (RESET low, asynchronous): last_grant=STORE, so FETCH has the highest priority first; all tag-pipeline valid bits cleared.
- Outputs while in reset: every *_ready, *_rsp_valid, rsp_exc_valid, mem_en and mem_we are 0. All data/address outputs and rsp_exc_code are 0.
- Reset mid-operation: in-flight accesses are lost and no response is produced for them. Requesters must re-issue after reset deasserts.
- Handshake: a requester holds valid and its payload stable until ready. ready is combinational from the valids and last_grant. At most one ready is asserted per cycle. An accepted request is valid&ready on a rising edge.
- Arbitration: round-robin order FETCH -> LOAD -> STORE. The search starts at the client after last_grant. last_grant updates only on an accepted request.
- Idle: no valids means no grant, mem_en=0, last_grant held.
- Issue: mem_en/mem_we/mem_addr/mem_wdata are driven combinationally in the grant cycle.
- Misaligned address (addr[1:0]!=0): the request is still accepted (ready=1) but mem_en stays 0. The tag carries an error with code 0 (fetch), 4 (load) or 6 (store).
- Tag pipeline: MEM_LATENCY stages, each holding {valid, client[1:0], err, code[3:0]}. A tag enters at acceptance and exits after exactly MEM_LATENCY cycles.
- Response cycle: exactly one *_rsp_valid for the exiting tag. Fetch and load responses carry mem_rdata, forced to 0 on error. rsp_exc_valid=err and rsp_exc_code=code; both are 0 when there is no error.
- Throughput: one accepted request per cycle. Responses are never back-pressured.
- Request/response overlap: a new acceptance and a response in the same cycle are independent and both occur.
- Flush: clears the valid bit of every in-flight FETCH tag, including one exiting this cycle, which is suppressed. It also suppresses a fetch acceptance in the same cycle (fetch_ready=0). LOAD/STORE tags and grants are unaffected.
- Stores: mem_we=1. The acknowledge arrives MEM_LATENCY cycles later for ordering, with no data.
- Width: only addr[1:0] are checked. The address is passed unmodified otherwise.

Test Plan:
- Reset ordering: hold RESET low with fetch_valid=1 -> fetch_ready=0 and mem_en=0. After release, the first edge grants fetch with mem_addr=fetch_addr=0x00000100 and mem_we=0. With MEM_LATENCY=1, fetch_rsp_valid=1 one cycle later with mem_rdata=0x00000013 passed through.
- Round-robin fairness: all three valid continuously with addresses 0x10/0x20/0x30 -> grants cycle FETCH, LOAD, STORE, FETCH... Each requester is served once every 3 cycles and responses return in the same order.
- Misaligned access: load_addr=0x00000102 -> load_ready=1 and mem_en=0. After MEM_LATENCY cycles load_rsp_valid=1, rsp_exc_valid=1, rsp_exc_code=4 and load_rsp_data=0. A store to 0x3 gives code 6.
- Flush: MEM_LATENCY=3, fetches accepted at cycles 0 and 1, load at cycle 2, flush at cycle 2 -> no fetch_rsp_valid ever. load_rsp_valid=1 at cycle 5.
- Async reset mid-flight: MEM_LATENCY=2, load accepted, RESET pulsed low mid-cycle -> outputs drop immediately and no load_rsp_valid after release. last_grant restarts so that fetch wins.
- Back-to-back mixed traffic: store 0xDEADBEEF to 0x40, then a load from 0x40 on the next cycle -> store_rsp_valid then load_rsp_valid on consecutive cycles, with load data equal to the memory model's returned 0xDEADBEEF.
